uart_rx_oversampled: RTL
========================

# uart_rx_oversampled

Serial receiver for the sensor UART link. It consumes the oversampled tick stream from the board's baud-rate tick generator, synchronises the asynchronous `rx` line, and recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop). It presents each byte to the command/sensor logic as a one-cycle valid pulse, with a separate framing-error pulse. Its `busy` output drives the tick generator's enable, so tick phase restarts at every start edge.

## Interface

Parameters:
- `OVERSAMPLING`, 8: ticks per bit. Must be even and ≥ 4; must equal the tick generator's oversampling setting.
- `DATA_BITS`, 8: payload bits per frame.

Ports:
- `clk`  input  1  system clock; all logic on rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `tick`  input  1  one-cycle pulse at baud × `OVERSAMPLING`; ignored while `busy`=0.
- `rx`  input  1  asynchronous serial line, idle high.
- `busy`  output  1  high from start-edge detection until return to IDLE; connect to tick-generator `enable`.
- `data`  output  `DATA_BITS`  last received byte; held until the next frame completes.
- `data_valid`  output  1  one-cycle pulse, good stop bit.
- `frame_err`  output  1  one-cycle pulse, stop bit sampled low.

## Operation

- `rx` passes through a 2-flop synchroniser (`rx_s`). Both flops reset to 1.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: when `rx_s`=0, go to START, clear `tick_cnt` and `bit_cnt`, and set `busy`=1. No tick is required.
- START: count ticks. On tick number `OVERSAMPLING`/2, sample `rx_s`:
  - 0: go to DATA and clear `tick_cnt`.
  - 1: glitch. Go to IDLE with no output.
- DATA: on tick number `OVERSAMPLING`, sample `rx_s`, shift right into `shreg` (new bit enters the MSB), increment `bit_cnt`, and clear `tick_cnt`. After bit `DATA_BITS`-1, go to STOP.
- STOP: on tick number `OVERSAMPLING`, sample `rx_s`:
  - 1: load `data`←`shreg`, pulse `data_valid`, go to IDLE.
  - 0: pulse `frame_err`; `data` is unchanged; go to BREAK.
- BREAK: wait for `rx_s`=1, then go to IDLE. `busy` stays 1.
- Counter widths:
  - `tick_cnt` is $clog2(`OVERSAMPLING`+1) bits and saturates at `OVERSAMPLING`, never wrapping.
  - `bit_cnt` is $clog2(`DATA_BITS`) bits.
- Reset values: `busy`=0, `data`=0, `data_valid`=0, `frame_err`=0, state=IDLE, `shreg`=0.
- Reset mid-frame aborts the frame with no pulses. Any later frame is received normally.
- `data_valid` and `frame_err` are never high together.

## Timing

- The synchroniser adds 2 cycles from `rx` pin to `rx_s`.
- `busy` rises in the cycle after `rx_s` is first seen low in IDLE.
- `data_valid` / `frame_err` assert in the cycle after the clock edge that registers the STOP sample tick. `data` updates on the same edge as `data_valid` rises.
- `busy` falls on the same edge that returns the FSM to IDLE:
  - the edge after the STOP sample for a good frame;
  - the edge after `rx_s`=1 is seen in BREAK.
- A new start edge may be accepted in the first IDLE cycle, so back-to-back frames need no gap beyond the stop bit.
- Each bit is sampled at mid-bit ±1 tick. Tolerated total baud mismatch is ≥ ±3% with `OVERSAMPLING`=8.

## Structure

- Shared package `uart_pkg`:
  - FSM state encoding for IDLE/START/DATA/STOP/BREAK;
  - default `OVERSAMPLING` and `DATA_BITS`;
  - the frame constants START_LVL=0 and STOP_LVL=1.
- One sub-module, `rx_sync`: 2-flop synchroniser with reset value 1, reusable for other async inputs.
- The tick generator is not instantiated here. The board top connects the generator's `tick` and `enable` to this block.

## Test plan

- Byte 0xA5, `OVERSAMPLING`=8, ideal ticks → `data`=0xA5, `data_valid` high exactly 1 cycle, `frame_err`=0, `busy` low afterwards.
- `rx` low for 2 ticks, then high → no `data_valid`/`frame_err`, FSM back in IDLE, `data` unchanged.
- Byte 0x3C with stop bit driven 0 for 3 bit times → one `frame_err` pulse, no `data_valid`, `busy` held until `rx` high. A following 0x5A is received correctly.
- Back-to-back frames 0x00, 0xFF with no idle gap → two `data_valid` pulses with `data`=0x00, then 0xFF.
- `rst_n`=0 for 1 cycle during data bit 4 of 0x81 → all outputs 0 next cycle, no pulses. Next frame 0x81 is received correctly.
- Sender at 115200 ±3% against ticks for nominal 115200, bytes 0x55 and 0xAA → both received without error.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: FSM encoding, default frame
// geometry and line levels.
package uart_pkg;

  localparam int DEFAULT_OVERSAMPLING = 8;
  localparam int DEFAULT_DATA_BITS    = 8;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input; both flops
// come out of reset at RESET_VAL so an idle-high line shows no false edge.
module rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments keep the two stages a true shift register;
  // blocking ones would collapse them into a single flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1-style UART receiver driven by an oversampled tick stream; busy gates
// the external tick generator so tick phase restarts at every start edge.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int OVERSAMPLING = DEFAULT_OVERSAMPLING,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic                 busy,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_err
);

  localparam int TW = $clog2(OVERSAMPLING + 1);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLING / 2);
  localparam logic [TW-1:0] TICK_FULL = TW'(OVERSAMPLING);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 rx_s;
  logic [2:0]           state;
  logic [TW-1:0]        tick_cnt;
  logic [TW-1:0]        tick_nxt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;

  rx_sync #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // Count of the tick being consumed now; parks at OVERSAMPLING rather than wrapping.
  assign tick_nxt = (tick_cnt == TICK_FULL) ? TICK_FULL : tick_cnt + TW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      // NOTE: shreg is fully rewritten before every use, but it is reset anyway
      // so the datapath never carries X into simulation or equivalence runs.
      shreg      <= '0;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (rx_s == START_LVL) begin
            state    <= ST_START;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b1;
          end
        end

        // Half a bit in: confirm the start level, otherwise treat it as a glitch.
        ST_START: begin
          if (tick) begin
            if (tick_nxt == TICK_MID) begin
              tick_cnt <= '0;
              if (rx_s == START_LVL) begin
                state <= ST_DATA;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_nxt;
            end
          end
        end

        ST_DATA: begin
          if (tick) begin
            if (tick_nxt == TICK_FULL) begin
              tick_cnt <= '0;
              shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
              bit_cnt  <= bit_cnt + BW'(1);
              if (bit_cnt == BIT_LAST) state <= ST_STOP;
            end else begin
              tick_cnt <= tick_nxt;
            end
          end
        end

        ST_STOP: begin
          if (tick) begin
            if (tick_nxt == TICK_FULL) begin
              tick_cnt <= '0;
              if (rx_s == STOP_LVL) begin
                data       <= shreg;
                data_valid <= 1'b1;
                state      <= ST_IDLE;
                busy       <= 1'b0;
              end else begin
                frame_err <= 1'b1;
                state     <= ST_BREAK;
              end
            end else begin
              tick_cnt <= tick_nxt;
            end
          end
        end

        // Line held low past the stop bit: stay busy until it returns to idle.
        ST_BREAK: begin
          if (rx_s == STOP_LVL) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
